// File: rtl/ik_swift_iter_ctrl.sv
// Iteration sequencer for the ik_swift IK core: pulses the core through
// reset/enable/done passes, feeds DH parameters back, stops on convergence/limit/watchdog/abort.
module ik_swift_iter_ctrl #(
    parameter int N           = 6,
    parameter int DATA_W      = 36,
    parameter int DH_W        = 21,
    parameter int ITER_W      = 8,
    parameter int WDOG_CYCLES = 4095
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [N*DATA_W-1:0]   target_in,
    input  logic [N*DH_W-1:0]     dh_init,
    input  logic [ITER_W-1:0]     max_iter,
    input  logic [DATA_W-2:0]     tol,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic                  timeout,
    output logic [ITER_W-1:0]     iter_count,
    output logic [N*DH_W-1:0]     dh_result,
    output logic                  core_rst,
    output logic                  core_en,
    input  logic                  core_done,
    output logic [N*DATA_W-1:0]   core_target,
    output logic [N*DH_W-1:0]     core_dh_in,
    input  logic [N*DH_W-1:0]     core_dh_out,
    input  logic [N*DATA_W-1:0]   core_delta
);

    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_CRST, S_RUN, S_CHECK, S_FIN, S_ABRT} state_t;

    state_t                    state_q, state_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      converged_q, converged_d;
    logic                      timeout_q, timeout_d;
    logic                      core_rst_q, core_rst_d;
    logic                      core_en_q, core_en_d;
    logic [ITER_W-1:0]         iter_q, iter_d;
    logic [ITER_W-1:0]         max_iter_q, max_iter_d;
    logic [DATA_W-2:0]         tol_q, tol_d;
    logic [N*DH_W-1:0]         dh_result_q, dh_result_d;
    logic [N*DH_W-1:0]         core_dh_in_q, core_dh_in_d;
    logic [N*DATA_W-1:0]       core_target_q, core_target_d;
    logic [N-1:0][DATA_W-2:0]  abs_q, abs_d;
    logic [WD_W-1:0]           wdog_q, wdog_d;
    logic                      conv_now;

    // The most negative input has no positive twin, so it clamps to the largest magnitude.
    function automatic logic [DATA_W-2:0] sat_abs(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] neg;
        neg = -x;
        if (!x[DATA_W-1])
            return x[DATA_W-2:0];
        if (x[DATA_W-2:0] == '0)
            return {(DATA_W-1){1'b1}};
        return neg[DATA_W-2:0];
    endfunction

    always_comb begin
        conv_now = 1'b1;
        for (int i = 0; i < N; i++)
            if (abs_q[i] > tol_q)
                conv_now = 1'b0;
    end

    always_comb begin
        // NOTE: every _d starts from its held value so no path through the case infers a latch.
        state_d       = state_q;
        converged_d   = converged_q;
        timeout_d     = timeout_q;
        iter_d        = iter_q;
        max_iter_d    = max_iter_q;
        tol_d         = tol_q;
        dh_result_d   = dh_result_q;
        core_dh_in_d  = core_dh_in_q;
        core_target_d = core_target_q;
        abs_d         = abs_q;
        wdog_d        = wdog_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    core_target_d = target_in;
                    core_dh_in_d  = dh_init;
                    max_iter_d    = max_iter;
                    tol_d         = tol;
                    iter_d        = '0;
                    converged_d   = 1'b0;
                    timeout_d     = 1'b0;
                    if (max_iter == '0) begin
                        dh_result_d = dh_init;
                        state_d     = S_FIN;
                    end else begin
                        state_d     = S_CRST;
                    end
                end
            end
            S_CRST: begin
                wdog_d  = '0;
                state_d = abort ? S_ABRT : S_RUN;
            end
            S_RUN: begin
                wdog_d = wdog_q + WD_W'(1);
                if (abort) begin
                    state_d = S_ABRT;
                end else if (core_done) begin
                    core_dh_in_d = core_dh_out;
                    dh_result_d  = core_dh_out;
                    for (int i = 0; i < N; i++)
                        abs_d[i] = sat_abs(core_delta[i*DATA_W +: DATA_W]);
                    state_d = S_CHECK;
                end else if (wdog_d == WD_W'(WDOG_CYCLES)) begin
                    timeout_d = 1'b1;
                    state_d   = S_FIN;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d = S_ABRT;
                end else begin
                    iter_d = iter_q + ITER_W'(1);
                    if (conv_now) begin
                        converged_d = 1'b1;
                        state_d     = S_FIN;
                    end else if (iter_d == max_iter_q) begin
                        state_d     = S_FIN;
                    end else begin
                        state_d     = S_CRST;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_ABRT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes are decoded from the next state so each one is high exactly while in its state.
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FIN);
        core_rst_d = (state_d == S_CRST) || (state_d == S_ABRT);
        core_en_d  = (state_d == S_RUN);
    end

    // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            converged_q   <= 1'b0;
            timeout_q     <= 1'b0;
            core_rst_q    <= 1'b0;
            core_en_q     <= 1'b0;
            iter_q        <= '0;
            max_iter_q    <= '0;
            tol_q         <= '0;
            dh_result_q   <= '0;
            core_dh_in_q  <= '0;
            core_target_q <= '0;
            abs_q         <= '0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            converged_q   <= converged_d;
            timeout_q     <= timeout_d;
            core_rst_q    <= core_rst_d;
            core_en_q     <= core_en_d;
            iter_q        <= iter_d;
            max_iter_q    <= max_iter_d;
            tol_q         <= tol_d;
            dh_result_q   <= dh_result_d;
            core_dh_in_q  <= core_dh_in_d;
            core_target_q <= core_target_d;
            abs_q         <= abs_d;
            wdog_q        <= wdog_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign converged   = converged_q;
    assign timeout     = timeout_q;
    assign iter_count  = iter_q;
    assign dh_result   = dh_result_q;
    assign core_rst    = core_rst_q;
    assign core_en     = core_en_q;
    assign core_target = core_target_q;
    assign core_dh_in  = core_dh_in_q;

endmodule
